// File: rtl/elink_link.sv
// Simplified single-clock eLink transceiver: three arbitrated TX channels framed onto a byte link,
// received frames decoded onto three RX channels, plus chip clock/reset generation and a mailbox counter.
module elink_link #(
    parameter logic [3:0] ROWID           = 4'h2,
    parameter logic [3:0] COLID           = 4'h3,
    parameter int         MBOX_DEPTH      = 4,
    parameter int         CHIP_RST_CYCLES = 16
) (
    input  logic       clkin,
    input  logic       hard_reset,
    input  logic       txwr_clk,
    input  logic       txrd_clk,
    input  logic       txrr_clk,
    input  logic       rxwr_clk,
    input  logic       rxrd_clk,
    input  logic       rxrr_clk,
    input  logic       txwr_access,
    input  logic [1:0] txwr_packet,
    output logic       txwr_wait,
    input  logic       txrd_access,
    input  logic [1:0] txrd_packet,
    output logic       txrd_wait,
    input  logic       txrr_access,
    input  logic [1:0] txrr_packet,
    output logic       txrr_wait,
    output logic       rxwr_access,
    output logic [1:0] rxwr_packet,
    input  logic       rxwr_wait,
    output logic       rxrd_access,
    output logic [1:0] rxrd_packet,
    input  logic       rxrd_wait,
    output logic       rxrr_access,
    output logic [1:0] rxrr_packet,
    input  logic       rxrr_wait,
    output logic [7:0] txo_data_p,
    output logic [7:0] txo_data_n,
    output logic       txo_frame_p,
    output logic       txo_frame_n,
    output logic       txo_lclk_p,
    output logic       txo_lclk_n,
    input  logic       txi_wr_wait_p,
    input  logic       txi_wr_wait_n,
    input  logic       txi_rd_wait_p,
    input  logic       txi_rd_wait_n,
    input  logic [7:0] rxi_data_p,
    input  logic [7:0] rxi_data_n,
    input  logic       rxi_frame_p,
    input  logic       rxi_frame_n,
    input  logic       rxi_lclk_p,
    input  logic       rxi_lclk_n,
    output logic       rxo_wr_wait_p,
    output logic       rxo_wr_wait_n,
    output logic       rxo_rd_wait_p,
    output logic       rxo_rd_wait_n,
    input  logic [2:0] clkbypass,
    output logic       cclk_p,
    output logic       cclk_n,
    output logic       chip_resetb,
    output logic [3:0] rowid,
    output logic [3:0] colid,
    output logic       mailbox_not_empty,
    output logic       mailbox_full
);

    localparam logic [1:0] T_WR = 2'b01;
    localparam logic [1:0] T_RD = 2'b10;
    localparam logic [1:0] T_RR = 2'b11;
    localparam logic [3:0] MB_MAX = 4'(MBOX_DEPTH);
    localparam int RCW = $clog2(CHIP_RST_CYCLES + 1) + 1;
    localparam logic [RCW-1:0] RST_LIM = RCW'(CHIP_RST_CYCLES);

    // Channel index 0 = write, 1 = read, 2 = read response.
    logic [2:0]      tx_acc;
    logic [2:0][1:0] tx_pkt;
    logic [2:0]      txv_q, txv_d;
    logic [2:0][1:0] txp_q, txp_d;
    logic [7:0]      txd_q, txd_d;
    logic            txf_q, txf_d;

    logic [2:0]      rx_wait;
    logic [2:0]      rx_hot;
    logic [2:0]      rxv_q, rxv_d;
    logic [2:0][1:0] rxp_q, rxp_d;

    logic [3:0]      mb_q, mb_d;
    logic            mb_inc, mb_dec;

    logic            lclk_q;
    logic            cclk_q;
    logic [2:0]      cdiv_q;
    logic [RCW-1:0]  rcnt_q, rcnt_d;
    logic            rstb_q;

    always_comb begin
        tx_acc = {txrr_access, txrd_access, txwr_access};
        tx_pkt = {txrr_packet, txrd_packet, txwr_packet};
        txv_d  = txv_q;
        txp_d  = txp_q;
        txd_d  = 8'h00;
        txf_d  = 1'b0;
        // Fixed priority rr > rd > wr, gated by the matching remote stall.
        if (txv_q[2] && !txi_rd_wait_p) begin
            txf_d    = 1'b1;
            txd_d    = {T_RR, 4'b0000, txp_q[2]};
            txv_d[2] = 1'b0;
        end else if (txv_q[1] && !txi_rd_wait_p) begin
            txf_d    = 1'b1;
            txd_d    = {T_RD, 4'b0000, txp_q[1]};
            txv_d[1] = 1'b0;
        end else if (txv_q[0] && !txi_wr_wait_p) begin
            txf_d    = 1'b1;
            txd_d    = {T_WR, 4'b0000, txp_q[0]};
            txv_d[0] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (tx_acc[i] && !txv_q[i]) begin
                txv_d[i] = 1'b1;
                txp_d[i] = tx_pkt[i];
            end
        end
    end

    always_comb begin
        rx_wait = {rxrr_wait, rxrd_wait, rxwr_wait};
        rx_hot  = 3'b000;
        if (rxi_frame_p) begin
            rx_hot = {rxi_data_p[7:6] == T_RR, rxi_data_p[7:6] == T_RD, rxi_data_p[7:6] == T_WR};
        end
        rxv_d = rxv_q;
        rxp_d = rxp_q;
        for (int i = 0; i < 3; i++) begin
            if (rxv_q[i] && !rx_wait[i]) begin
                rxv_d[i] = 1'b0;
            end
            // A frame aimed at a buffer that was full on this edge is dropped.
            if (rx_hot[i] && !rxv_q[i]) begin
                rxv_d[i] = 1'b1;
                rxp_d[i] = rxi_data_p[1:0];
            end
        end
        mb_inc = rx_hot[0] && !rxv_q[0] && (rxi_data_p[1:0] == 2'b11) && (mb_q != MB_MAX);
        mb_dec = rx_hot[1] && !rxv_q[1] && (rxi_data_p[1:0] == 2'b11) && (mb_q != 4'd0);
        mb_d   = mb_q;
        if (mb_inc && !mb_dec) begin
            mb_d = mb_q + 4'd1;
        end else if (mb_dec && !mb_inc) begin
            mb_d = mb_q - 4'd1;
        end
        rcnt_d = (rcnt_q == RST_LIM) ? rcnt_q : rcnt_q + 1'b1;
    end

    always_ff @(posedge clkin) begin
        if (hard_reset) begin
            txv_q  <= 3'b000;
            txd_q  <= 8'h00;
            txf_q  <= 1'b0;
            rxv_q  <= 3'b000;
            rxp_q  <= '0;
            mb_q   <= 4'd0;
            lclk_q <= 1'b0;
            cclk_q <= 1'b0;
            cdiv_q <= 3'd0;
            rcnt_q <= '0;
            rstb_q <= 1'b0;
        end else begin
            txv_q  <= txv_d;
            txd_q  <= txd_d;
            txf_q  <= txf_d;
            rxv_q  <= rxv_d;
            rxp_q  <= rxp_d;
            mb_q   <= mb_d;
            lclk_q <= ~lclk_q;
            if (cdiv_q == clkbypass) begin
                cdiv_q <= 3'd0;
                cclk_q <= ~cclk_q;
            end else begin
                cdiv_q <= cdiv_q + 3'd1;
            end
            rcnt_q <= rcnt_d;
            rstb_q <= (rcnt_d == RST_LIM);
        end
    end

    // TX payload storage is only meaningful while its valid bit is set, so it needs no reset.
    always_ff @(posedge clkin) begin
        txp_q <= txp_d;
    end

    assign txwr_wait         = txv_q[0];
    assign txrd_wait         = txv_q[1];
    assign txrr_wait         = txv_q[2];
    assign rxwr_access       = rxv_q[0];
    assign rxrd_access       = rxv_q[1];
    assign rxrr_access       = rxv_q[2];
    assign rxwr_packet       = rxp_q[0];
    assign rxrd_packet       = rxp_q[1];
    assign rxrr_packet       = rxp_q[2];
    assign txo_data_p        = txd_q;
    assign txo_data_n        = ~txd_q;
    assign txo_frame_p       = txf_q;
    assign txo_frame_n       = ~txf_q;
    assign txo_lclk_p        = lclk_q;
    assign txo_lclk_n        = ~lclk_q;
    assign rxo_wr_wait_p     = rxv_q[0];
    assign rxo_wr_wait_n     = ~rxv_q[0];
    assign rxo_rd_wait_p     = rxv_q[1] | rxv_q[2];
    assign rxo_rd_wait_n     = ~(rxv_q[1] | rxv_q[2]);
    assign cclk_p            = cclk_q;
    assign cclk_n            = ~cclk_q;
    assign chip_resetb       = rstb_q;
    assign rowid             = ROWID;
    assign colid             = COLID;
    assign mailbox_not_empty = (mb_q != 4'd0);
    assign mailbox_full      = (mb_q == MB_MAX);

    logic unused_inputs;
    assign unused_inputs = ^{txwr_clk, txrd_clk, txrr_clk, rxwr_clk, rxrd_clk, rxrr_clk,
                             txi_wr_wait_n, txi_rd_wait_n, rxi_data_n, rxi_frame_n,
                             rxi_lclk_p, rxi_lclk_n, rxi_data_p[5:2]};

endmodule

// File: tb/tb_elink_link.sv
// Bench for elink_link: directed scenarios plus a randomized run against a buffer-level reference model.
module tb_elink_link;

    logic clkin = 1'b0;
    always #5 clkin = ~clkin;

    logic       hard_reset = 1'b1;
    logic       clk_tie = 1'b0;
    logic       txwr_access = 0, txrd_access = 0, txrr_access = 0;
    logic [1:0] txwr_packet = 0, txrd_packet = 0, txrr_packet = 0;
    logic       txwr_wait, txrd_wait, txrr_wait;
    logic       rxwr_access, rxrd_access, rxrr_access;
    logic [1:0] rxwr_packet, rxrd_packet, rxrr_packet;
    logic       rxwr_wait = 0, rxrd_wait = 0, rxrr_wait = 0;
    logic [7:0] txo_data_p, txo_data_n;
    logic       txo_frame_p, txo_frame_n, txo_lclk_p, txo_lclk_n;
    logic       txi_wr_wait_p = 0, txi_rd_wait_p = 0;
    logic       txi_wr_wait_n, txi_rd_wait_n;
    logic [7:0] rxi_data_p = 0;
    logic [7:0] rxi_data_n;
    logic       rxi_frame_p = 0;
    logic       rxi_frame_n;
    logic       rxo_wr_wait_p, rxo_wr_wait_n, rxo_rd_wait_p, rxo_rd_wait_n;
    logic [2:0] clkbypass = 3'd0;
    logic       cclk_p, cclk_n, chip_resetb;
    logic [3:0] rowid, colid;
    logic       mailbox_not_empty, mailbox_full;

    assign txi_wr_wait_n = ~txi_wr_wait_p;
    assign txi_rd_wait_n = ~txi_rd_wait_p;
    assign rxi_data_n    = ~rxi_data_p;
    assign rxi_frame_n   = ~rxi_frame_p;

    elink_link dut (
        .clkin(clkin), .hard_reset(hard_reset),
        .txwr_clk(clk_tie), .txrd_clk(clk_tie), .txrr_clk(clk_tie),
        .rxwr_clk(clk_tie), .rxrd_clk(clk_tie), .rxrr_clk(clk_tie),
        .txwr_access(txwr_access), .txwr_packet(txwr_packet), .txwr_wait(txwr_wait),
        .txrd_access(txrd_access), .txrd_packet(txrd_packet), .txrd_wait(txrd_wait),
        .txrr_access(txrr_access), .txrr_packet(txrr_packet), .txrr_wait(txrr_wait),
        .rxwr_access(rxwr_access), .rxwr_packet(rxwr_packet), .rxwr_wait(rxwr_wait),
        .rxrd_access(rxrd_access), .rxrd_packet(rxrd_packet), .rxrd_wait(rxrd_wait),
        .rxrr_access(rxrr_access), .rxrr_packet(rxrr_packet), .rxrr_wait(rxrr_wait),
        .txo_data_p(txo_data_p), .txo_data_n(txo_data_n),
        .txo_frame_p(txo_frame_p), .txo_frame_n(txo_frame_n),
        .txo_lclk_p(txo_lclk_p), .txo_lclk_n(txo_lclk_n),
        .txi_wr_wait_p(txi_wr_wait_p), .txi_wr_wait_n(txi_wr_wait_n),
        .txi_rd_wait_p(txi_rd_wait_p), .txi_rd_wait_n(txi_rd_wait_n),
        .rxi_data_p(rxi_data_p), .rxi_data_n(rxi_data_n),
        .rxi_frame_p(rxi_frame_p), .rxi_frame_n(rxi_frame_n),
        .rxi_lclk_p(clk_tie), .rxi_lclk_n(clk_tie),
        .rxo_wr_wait_p(rxo_wr_wait_p), .rxo_wr_wait_n(rxo_wr_wait_n),
        .rxo_rd_wait_p(rxo_rd_wait_p), .rxo_rd_wait_n(rxo_rd_wait_n),
        .clkbypass(clkbypass), .cclk_p(cclk_p), .cclk_n(cclk_n),
        .chip_resetb(chip_resetb), .rowid(rowid), .colid(colid),
        .mailbox_not_empty(mailbox_not_empty), .mailbox_full(mailbox_full)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one-entry buffers per channel (0 wr, 1 rd, 2 rr) and a mailbox count.
    logic [2:0] mv = 0;
    logic [1:0] mp [3] = '{default: 2'b00};
    logic [2:0] rv = 0;
    logic [1:0] rp [3] = '{default: 2'b00};
    int         mcnt = 0;
    logic [7:0] e_data = 0;
    logic       e_frame = 0;

    task automatic model_edge();
        logic [2:0] acc, old_tx, old_rx, rw;
        logic [1:0] pk [3];
        int sel, ch;
        acc = {txrr_access, txrd_access, txwr_access};
        pk[0] = txwr_packet; pk[1] = txrd_packet; pk[2] = txrr_packet;
        rw = {rxrr_wait, rxrd_wait, rxwr_wait};
        if (hard_reset) begin
            mv = 0; rv = 0; mcnt = 0; e_data = 0; e_frame = 0;
            for (int i = 0; i < 3; i++) rp[i] = 2'b00;
        end else begin
            sel = -1;
            if (mv[2] && !txi_rd_wait_p) sel = 2;
            else if (mv[1] && !txi_rd_wait_p) sel = 1;
            else if (mv[0] && !txi_wr_wait_p) sel = 0;
            old_tx = mv;
            if (sel >= 0) begin
                e_frame = 1'b1;
                e_data  = {2'(sel + 1), 4'b0000, mp[sel]};
                mv[sel] = 1'b0;
            end else begin
                e_frame = 1'b0;
                e_data  = 8'h00;
            end
            for (int i = 0; i < 3; i++)
                if (acc[i] && !old_tx[i]) begin mv[i] = 1'b1; mp[i] = pk[i]; end
            old_rx = rv;
            for (int i = 0; i < 3; i++)
                if (old_rx[i] && !rw[i]) rv[i] = 1'b0;
            if (rxi_frame_p && rxi_data_p[7:6] != 2'b00) begin
                ch = int'(rxi_data_p[7:6]) - 1;
                if (!old_rx[ch]) begin
                    rv[ch] = 1'b1;
                    rp[ch] = rxi_data_p[1:0];
                    if (rxi_data_p[1:0] == 2'b11) begin
                        if (ch == 0 && mcnt < 4) mcnt++;
                        if (ch == 1 && mcnt > 0) mcnt--;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clkin);
        #1;
    endtask

    task automatic test_reset();
        int k;
        hard_reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({txo_data_p, txo_data_n, txo_frame_p, txo_frame_n, txo_lclk_p, txo_lclk_n, cclk_p, cclk_n, chip_resetb}
            !== {8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_link got=%h/%h f%b%b l%b%b c%b%b rb%b required=00/ff f01 l01 c01 rb0",
                     txo_data_p, txo_data_n, txo_frame_p, txo_frame_n, txo_lclk_p, txo_lclk_n, cclk_p, cclk_n, chip_resetb);
        end
        total++;
        if ({txwr_wait, txrd_wait, txrr_wait, rxo_wr_wait_p, rxo_wr_wait_n, rxo_rd_wait_p, rxo_rd_wait_n} !== 7'b0000101) begin
            bad++;
            $display("FAIL reset_waits got=%b required=0000101",
                     {txwr_wait, txrd_wait, txrr_wait, rxo_wr_wait_p, rxo_wr_wait_n, rxo_rd_wait_p, rxo_rd_wait_n});
        end
        total++;
        if ({rxwr_access, rxrd_access, rxrr_access, rxwr_packet, rxrd_packet, rxrr_packet, mailbox_not_empty, mailbox_full} !== 11'd0) begin
            bad++;
            $display("FAIL reset_rx got=%b required=0",
                     {rxwr_access, rxrd_access, rxrr_access, rxwr_packet, rxrd_packet, rxrr_packet, mailbox_not_empty, mailbox_full});
        end
        hard_reset = 1'b0;
        k = 0;
        while (k < 40) begin
            tick();
            k++;
            if (chip_resetb === 1'b1) break;
        end
        total++;
        if (k != 16 || chip_resetb !== 1'b1) begin
            bad++;
            $display("FAIL chip_resetb_delay got=%0d cycles (resetb=%b) required=16", k, chip_resetb);
        end
        total++;
        if ({rowid, colid} !== 8'h23) begin
            bad++;
            $display("FAIL rowid_colid got=%h required=23", {rowid, colid});
        end
    endtask

    task automatic test_tx_single();
        txwr_access = 1'b1; txwr_packet = 2'b10;
        tick();
        txwr_access = 1'b0;
        total++;
        if ({txwr_wait, txo_frame_p} !== 2'b10) begin
            bad++; $display("FAIL tx_single_wait got=%b required=10", {txwr_wait, txo_frame_p});
        end
        tick();
        total++;
        if ({txwr_wait, txo_frame_p, txo_data_p, txo_data_n} !== {1'b0, 1'b1, 8'h42, 8'hBD}) begin
            bad++;
            $display("FAIL tx_single_frame got=w%b f%b %h/%h required=w0 f1 42/bd", txwr_wait, txo_frame_p, txo_data_p, txo_data_n);
        end
        tick();
        total++;
        if ({txo_frame_p, txo_data_p} !== 9'd0) begin
            bad++; $display("FAIL tx_single_idle got=f%b %h required=f0 00", txo_frame_p, txo_data_p);
        end
    endtask

    task automatic test_tx_arb();
        txi_rd_wait_p = 1'b1;
        txwr_access = 1; txrd_access = 1; txrr_access = 1;
        txwr_packet = 2'd1; txrd_packet = 2'd2; txrr_packet = 2'd3;
        tick();
        txwr_access = 0; txrd_access = 0; txrr_access = 0;
        total++;
        if ({txwr_wait, txrd_wait, txrr_wait, txo_frame_p} !== 4'b1110) begin
            bad++; $display("FAIL arb_capture got=%b required=1110", {txwr_wait, txrd_wait, txrr_wait, txo_frame_p});
        end
        tick();
        total++;
        if ({txo_frame_p, txo_data_p} !== {1'b1, 8'h41}) begin
            bad++; $display("FAIL arb_wr_first got=f%b %h required=f1 41", txo_frame_p, txo_data_p);
        end
        tick();
        total++;
        if ({txo_frame_p, txwr_wait, txrd_wait, txrr_wait} !== 4'b0011) begin
            bad++; $display("FAIL arb_rd_stalled got=%b required=0011", {txo_frame_p, txwr_wait, txrd_wait, txrr_wait});
        end
        txi_rd_wait_p = 1'b0;
        tick();
        total++;
        if ({txo_frame_p, txo_data_p} !== {1'b1, 8'hC3}) begin
            bad++; $display("FAIL arb_rr got=f%b %h required=f1 c3", txo_frame_p, txo_data_p);
        end
        tick();
        total++;
        if ({txo_frame_p, txo_data_p} !== {1'b1, 8'h82}) begin
            bad++; $display("FAIL arb_rd got=f%b %h required=f1 82", txo_frame_p, txo_data_p);
        end
        tick();
        total++;
        if ({txo_frame_p, txwr_wait, txrd_wait, txrr_wait} !== 4'b0000) begin
            bad++; $display("FAIL arb_drained got=%b required=0000", {txo_frame_p, txwr_wait, txrd_wait, txrr_wait});
        end
    endtask

    task automatic test_rx_stall();
        rxrr_wait = 1'b1;
        rxi_frame_p = 1'b1; rxi_data_p = 8'hC1;
        tick();
        total++;
        if ({rxrr_access, rxrr_packet, rxo_rd_wait_p, rxo_rd_wait_n} !== 5'b10110) begin
            bad++; $display("FAIL rx_load got=%b required=10110", {rxrr_access, rxrr_packet, rxo_rd_wait_p, rxo_rd_wait_n});
        end
        rxi_data_p = 8'hC2;
        tick();
        rxi_frame_p = 1'b0;
        total++;
        if ({rxrr_access, rxrr_packet} !== 3'b101) begin
            bad++; $display("FAIL rx_drop_full got=%b required=101", {rxrr_access, rxrr_packet});
        end
        tick();
        total++;
        if ({rxrr_access, rxrr_packet, rxo_rd_wait_p} !== 4'b1011) begin
            bad++; $display("FAIL rx_hold got=%b required=1011", {rxrr_access, rxrr_packet, rxo_rd_wait_p});
        end
        rxrr_wait = 1'b0;
        tick();
        total++;
        if ({rxrr_access, rxo_rd_wait_p} !== 2'b00) begin
            bad++; $display("FAIL rx_release got=%b required=00", {rxrr_access, rxo_rd_wait_p});
        end
    endtask

    task automatic test_mailbox();
        for (int i = 0; i < 5; i++) begin
            rxi_frame_p = 1'b1; rxi_data_p = 8'h43;
            tick();
            rxi_frame_p = 1'b0;
            total++;
            if ({mailbox_not_empty, mailbox_full, rxwr_access, rxwr_packet} !== {1'b1, (i >= 3), 1'b1, 2'b11}) begin
                bad++;
                $display("FAIL mbox_write%0d got=ne%b full%b acc%b pkt%b required=ne1 full%b acc1 pkt11",
                         i, mailbox_not_empty, mailbox_full, rxwr_access, rxwr_packet, (i >= 3));
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            rxi_frame_p = 1'b1; rxi_data_p = 8'h83;
            tick();
            rxi_frame_p = 1'b0;
            total++;
            if ({mailbox_not_empty, mailbox_full} !== {(i < 3), 1'b0}) begin
                bad++;
                $display("FAIL mbox_read%0d got=ne%b full%b required=ne%b full0", i, mailbox_not_empty, mailbox_full, (i < 3));
            end
            tick();
        end
    endtask

    task automatic measure_cclk(input logic [2:0] sel, input int want);
        logic prev;
        int n;
        bit found;
        clkbypass = sel;
        repeat (20) tick();
        found = 0;
        prev = cclk_p;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (prev === 1'b0 && cclk_p === 1'b1) found = 1;
            prev = cclk_p;
        end
        n = 0;
        if (found) begin
            found = 0;
            for (int i = 0; i < 40 && !found; i++) begin
                tick();
                n++;
                if (prev === 1'b0 && cclk_p === 1'b1) found = 1;
                prev = cclk_p;
            end
        end
        total++;
        if (!found || n != want || cclk_n !== ~cclk_p) begin
            bad++;
            $display("FAIL cclk_period_sel%0d got=%0d cycles (edge found=%0d) required=%0d", sel, n, found, want);
        end
    endtask

    task automatic test_cclk();
        measure_cclk(3'd3, 8);
        measure_cclk(3'd0, 2);
        measure_cclk(3'd1, 4);
    endtask

    task automatic test_random();
        logic prev_lclk;
        for (int i = 0; i < 400; i++) begin
            txwr_access = 1'($urandom_range(0, 1));
            txrd_access = 1'($urandom_range(0, 1));
            txrr_access = 1'($urandom_range(0, 1));
            txwr_packet = 2'($urandom);
            txrd_packet = 2'($urandom);
            txrr_packet = 2'($urandom);
            txi_wr_wait_p = ($urandom_range(0, 3) == 0);
            txi_rd_wait_p = ($urandom_range(0, 3) == 0);
            rxi_frame_p = 1'($urandom_range(0, 1));
            rxi_data_p  = 8'($urandom);
            rxwr_wait = ($urandom_range(0, 2) == 0);
            rxrd_wait = ($urandom_range(0, 2) == 0);
            rxrr_wait = ($urandom_range(0, 2) == 0);
            prev_lclk = txo_lclk_p;
            tick();
            total++;
            if ({txo_frame_p, txo_data_p, txo_data_n, txwr_wait, txrd_wait, txrr_wait}
                !== {e_frame, e_data, ~e_data, mv[0], mv[1], mv[2]}) begin
                bad++;
                $display("FAIL rand_tx cyc=%0d got=f%b %h/%h w%b%b%b required=f%b %h/%h w%b%b%b", i,
                         txo_frame_p, txo_data_p, txo_data_n, txwr_wait, txrd_wait, txrr_wait,
                         e_frame, e_data, ~e_data, mv[0], mv[1], mv[2]);
            end
            total++;
            if ({rxwr_access, rxrd_access, rxrr_access, rxwr_packet, rxrd_packet, rxrr_packet, rxo_wr_wait_p, rxo_rd_wait_p}
                !== {rv[0], rv[1], rv[2], rp[0], rp[1], rp[2], rv[0], rv[1] | rv[2]}) begin
                bad++;
                $display("FAIL rand_rx cyc=%0d got=%b required=%b", i,
                         {rxwr_access, rxrd_access, rxrr_access, rxwr_packet, rxrd_packet, rxrr_packet, rxo_wr_wait_p, rxo_rd_wait_p},
                         {rv[0], rv[1], rv[2], rp[0], rp[1], rp[2], rv[0], rv[1] | rv[2]});
            end
            total++;
            if ({mailbox_not_empty, mailbox_full, txo_lclk_p, txo_lclk_n} !== {(mcnt != 0), (mcnt == 4), ~prev_lclk, prev_lclk}) begin
                bad++;
                $display("FAIL rand_mbox_lclk cyc=%0d got=%b required=%b count=%0d", i,
                         {mailbox_not_empty, mailbox_full, txo_lclk_p, txo_lclk_n},
                         {(mcnt != 0), (mcnt == 4), ~prev_lclk, prev_lclk}, mcnt);
            end
        end
        txwr_access = 0; txrd_access = 0; txrr_access = 0;
        txi_wr_wait_p = 0; txi_rd_wait_p = 0;
        rxi_frame_p = 0; rxwr_wait = 0; rxrd_wait = 0; rxrr_wait = 0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        txi_wr_wait_p = 1'b1;
        txwr_access = 1'b1; txwr_packet = 2'd1;
        rxrd_wait = 1'b1;
        rxi_frame_p = 1'b1; rxi_data_p = 8'h82;
        tick();
        txwr_access = 1'b0; rxi_frame_p = 1'b0;
        total++;
        if ({txwr_wait, rxrd_access, rxrd_packet} !== 4'b1110) begin
            bad++; $display("FAIL mid_setup got=%b required=1110", {txwr_wait, rxrd_access, rxrd_packet});
        end
        hard_reset = 1'b1;
        tick();
        hard_reset = 1'b0;
        txi_wr_wait_p = 1'b0; rxrd_wait = 1'b0;
        total++;
        if ({txwr_wait, rxrd_access, rxrd_packet, rxo_rd_wait_p, chip_resetb} !== 6'b000000) begin
            bad++;
            $display("FAIL mid_reset_clear got=%b required=000000", {txwr_wait, rxrd_access, rxrd_packet, rxo_rd_wait_p, chip_resetb});
        end
        tick();
        tick();
        total++;
        if ({txo_frame_p, txo_data_p} !== 9'd0) begin
            bad++; $display("FAIL mid_packet_lost got=f%b %h required=f0 00", txo_frame_p, txo_data_p);
        end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_tx_arb();
        test_rx_stall();
        test_mailbox();
        test_cclk();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1);
    end

endmodule
